rssi_accum: RTL
===============

# rssi_accum

Consumer of the periodic `rssi_load` window strobe in the 15.36 MHz control domain. Computes the instantaneous power I²+Q² of each valid baseband sample and accumulates it over the current window. On each `rssi_load` pulse it latches the window total and sample count for register readback, then restarts accumulation. It sits between the RX sample stream and the `IFP_regs` status readback path.

## Interface
Parameters:
- `DATA_W`, 16, signed I/Q sample width
- `CNT_W`, 21, sample-count width (matches window tick width)
- `ACC_W`, 56, accumulator/result width; must be ≥ 2*DATA_W+1+CNT_W-2

Ports:
- `clk_15p36`  in  1  sole clock
- `resetn_15p36`  in  1  reset, synchronous, active-low
- `sample_valid`  in  1  I/Q sample qualifier
- `sample_i`  in  DATA_W  signed I
- `sample_q`  in  DATA_W  signed Q
- `rssi_load`  in  1  single-cycle window-end strobe
- `rssi_power`  out  ACC_W  latched window power sum
- `rssi_count`  out  CNT_W  latched number of samples in window
- `rssi_valid`  out  1  one-cycle pulse, new result latched
- `rssi_ovf`  out  1  latched: window accumulator saturated
- `rssi_peak`  out  2*DATA_W+1  latched max instantaneous power (see Configuration)

## Operation
- Power pipeline: stage 1 registers I, Q, valid; stage 2 registers I², Q² (each 2*DATA_W unsigned); stage 3 registers `pwr = I²+Q²` (2*DATA_W+1 bits) with `pwr_vld`.
- Width rule: I²+Q² ≤ 2^(2*DATA_W-1); -2^(DATA_W-1) squared is handled exactly (no wrap).
- Accumulator: on `pwr_vld`, `acc += pwr` with saturation at all-ones; sticky `acc_sat` set on saturation. `cnt += 1`, saturating at all-ones.
- On `rssi_load`: `rssi_power <= acc (+pwr if pwr_vld)`, `rssi_count <= cnt (+1 if pwr_vld)`, `rssi_ovf <= acc_sat | saturation on that add`; `acc`, `cnt`, `acc_sat` clear to 0. Power at stage 3 in the load cycle belongs to the closing window.
- Empty window (no valid samples): result 0/0, `rssi_valid` still pulses.
- Back-to-back `rssi_load` on consecutive cycles: each produces a result; second covers only the power in its own cycle.
- Reset: all pipeline, accumulator, and outputs to 0. Reset mid-window discards partial sums; no `rssi_valid` on reset exit.

## Timing
- `sample_valid` at cycle t → `pwr_vld` at t+3 (registered out of stage 3); it is added on the edge ending t+3.
- Samples with `sample_valid` at cycle ≤ L-3 land in the window closed by `rssi_load` at L; samples at ≥ L-2 go to the next window.
- `rssi_power/count/ovf` update, and `rssi_valid` is high, in cycle L+1 only; outputs hold until the next load.
- Throughput: one sample per cycle, no backpressure.

## Configuration
- `RSSI_PEAK_HOLD_EN` defined: running max of `pwr` per window, folded in the same cycle as accumulation (load-cycle power included), latched to `rssi_peak` with the other results, cleared at window start.
- Undefined: no peak logic; `rssi_peak` tied to 0.

## Structure
- Shared package `rssi_pkg`: `DATA_W`/`CNT_W`/`ACC_W` defaults, `PWR_W = 2*DATA_W+1` localparam, `rssi_result_t` struct {power, count, ovf, peak}.
- One sub-module: `rssi_pwr_calc`, the 3-stage I²+Q² pipeline (in: valid/I/Q, out: `pwr_vld`/`pwr`). Accumulate/latch logic stays in `rssi_accum`.

## Test plan
- Constant I=1000, Q=-1000 every cycle; load every 100 cycles → steady state `rssi_power`=200,000,000, `rssi_count`=100, `rssi_valid` one cycle after each load.
- I=Q=-32768 single sample → `pwr`=2^31 exactly; window result 2147483648, count 1.
- No `sample_valid` across a window → `rssi_power`=0, `rssi_count`=0, `rssi_valid` pulses.
- Sample boundary: valid only at L-3 and L-2 (I=1,Q=0) → window L reports count 1, next window reports count 1.
- Force `ACC_W`=34 build, full-scale input for 8 cycles → `rssi_power` all-ones, `rssi_ovf`=1; next window with small input clears `rssi_ovf`.
- Reset asserted mid-window after 50 samples, then load after 10 more → count 10; with `RSSI_PEAK_HOLD_EN`, `rssi_peak` equals the max power of those 10 samples.

Source files
------------

// File: rtl/rssi_pkg.sv
// Shared widths and the result payload for the RSSI window accumulator.
package rssi_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 21;
  localparam int unsigned ACC_W  = 56;
  localparam int unsigned PWR_W  = 2 * DATA_W + 1;

  typedef struct packed {
    logic [ACC_W-1:0] power;
    logic [CNT_W-1:0] count;
    logic             ovf;
    logic [PWR_W-1:0] peak;
  } rssi_result_t;

endpackage

// File: rtl/rssi_pwr_calc.sv
// Three-stage I^2+Q^2 pipeline: register inputs, square, then sum.
module rssi_pwr_calc #(
  parameter int unsigned DATA_W = rssi_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_i,
  input  logic [DATA_W-1:0] sample_q,
  output logic              pwr_vld,
  output logic [2*DATA_W:0] pwr
);
  import rssi_pkg::*;

  localparam int unsigned SQ_W = 2 * DATA_W;
  localparam int unsigned PW_W = 2 * DATA_W + 1;

  logic signed [DATA_W-1:0] i_r;
  logic signed [DATA_W-1:0] q_r;
  logic                     vld_r;
  logic [SQ_W-1:0]          i_sq;
  logic [SQ_W-1:0]          q_sq;
  logic                     sq_vld;

  logic signed [SQ_W-1:0]   i_ext_c;
  logic signed [SQ_W-1:0]   q_ext_c;
  logic signed [SQ_W-1:0]   i_prod_c;
  logic signed [SQ_W-1:0]   q_prod_c;

  // Full-width signed product: (-2^(DATA_W-1))^2 = 2^(2*DATA_W-2) still fits.
  always_comb begin
    i_ext_c  = SQ_W'(i_r);
    q_ext_c  = SQ_W'(q_r);
    i_prod_c = i_ext_c * i_ext_c;
    q_prod_c = q_ext_c * q_ext_c;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      i_r     <= '0;
      q_r     <= '0;
      vld_r   <= 1'b0;
      i_sq    <= '0;
      q_sq    <= '0;
      sq_vld  <= 1'b0;
      pwr     <= '0;
      pwr_vld <= 1'b0;
    end else begin
      i_r     <= sample_i;
      q_r     <= sample_q;
      vld_r   <= sample_valid;
      i_sq    <= i_prod_c;
      q_sq    <= q_prod_c;
      sq_vld  <= vld_r;
      pwr     <= PW_W'(i_sq) + PW_W'(q_sq);
      pwr_vld <= sq_vld;
    end
  end

endmodule

// File: rtl/rssi_accum.sv
// Windowed I^2+Q^2 accumulator latched on each rssi_load strobe.
// Optional running peak per window is enabled with RSSI_PEAK_HOLD_EN.
module rssi_accum #(
  parameter int unsigned DATA_W = rssi_pkg::DATA_W,
  parameter int unsigned CNT_W  = rssi_pkg::CNT_W,
  parameter int unsigned ACC_W  = rssi_pkg::ACC_W
) (
  input  logic                clk_15p36,
  input  logic                resetn_15p36,
  input  logic                sample_valid,
  input  logic [DATA_W-1:0]   sample_i,
  input  logic [DATA_W-1:0]   sample_q,
  input  logic                rssi_load,
  output logic [ACC_W-1:0]    rssi_power,
  output logic [CNT_W-1:0]    rssi_count,
  output logic                rssi_valid,
  output logic                rssi_ovf,
  output logic [2*DATA_W:0]   rssi_peak
);
  import rssi_pkg::*;

  localparam int unsigned PW_W  = 2 * DATA_W + 1;
  localparam int unsigned SUM_W = ACC_W + 1;

  logic             pwr_vld;
  logic [PW_W-1:0]  pwr;

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             acc_sat;

  logic [SUM_W-1:0] sum_c;
  logic             add_sat_c;
  logic [ACC_W-1:0] acc_nxt_c;
  logic [CNT_W-1:0] cnt_nxt_c;
  logic             sat_nxt_c;

  rssi_pwr_calc #(
    .DATA_W (DATA_W)
  ) u_pwr_calc (
    .clk          (clk_15p36),
    .resetn       (resetn_15p36),
    .sample_valid (sample_valid),
    .sample_i     (sample_i),
    .sample_q     (sample_q),
    .pwr_vld      (pwr_vld),
    .pwr          (pwr)
  );

  // Next window state including the stage-3 power of this cycle.
  always_comb begin
    sum_c     = {1'b0, acc} + SUM_W'(pwr);
    add_sat_c = sum_c[ACC_W];
    acc_nxt_c = acc;
    cnt_nxt_c = cnt;
    sat_nxt_c = acc_sat;
    if (pwr_vld) begin
      acc_nxt_c = add_sat_c ? '1 : sum_c[ACC_W-1:0];
      cnt_nxt_c = (&cnt) ? cnt : cnt + CNT_W'(1);
      sat_nxt_c = acc_sat | add_sat_c;
    end
  end

  always_ff @(posedge clk_15p36) begin
    if (!resetn_15p36) begin
      acc        <= '0;
      cnt        <= '0;
      acc_sat    <= 1'b0;
      rssi_power <= '0;
      rssi_count <= '0;
      rssi_ovf   <= 1'b0;
      rssi_valid <= 1'b0;
    end else begin
      rssi_valid <= rssi_load;
      if (rssi_load) begin
        rssi_power <= acc_nxt_c;
        rssi_count <= cnt_nxt_c;
        rssi_ovf   <= sat_nxt_c;
        acc        <= '0;
        cnt        <= '0;
        acc_sat    <= 1'b0;
      end else begin
        acc        <= acc_nxt_c;
        cnt        <= cnt_nxt_c;
        acc_sat    <= sat_nxt_c;
      end
    end
  end

`ifdef RSSI_PEAK_HOLD_EN
  logic [PW_W-1:0] peak;
  logic [PW_W-1:0] peak_nxt_c;

  always_comb begin
    peak_nxt_c = peak;
    if (pwr_vld && (pwr > peak)) begin
      peak_nxt_c = pwr;
    end
  end

  always_ff @(posedge clk_15p36) begin
    if (!resetn_15p36) begin
      peak      <= '0;
      rssi_peak <= '0;
    end else if (rssi_load) begin
      rssi_peak <= peak_nxt_c;
      peak      <= '0;
    end else begin
      peak      <= peak_nxt_c;
    end
  end
`else
  assign rssi_peak = '0;
`endif

endmodule
